// File: rtl/pe_conv_split.sv
// pe_conv_split: width down-converter. Accepts one IN_W-bit token and emits it
// as RATIO = IN_W/OUT_W consecutive OUT_W-bit beats over a valid/ready stream.
//
// Parameters:
//   IN_W      input token width
//   OUT_W     output beat width (IN_W must be a multiple, ratio >= 2)
//   MSB_FIRST 0: least-significant slice first, 1: most-significant first
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input token handshake (in_ready is combinational)
//   in_data               input token
//   out_valid/out_ready   output beat handshake
//   out_data              current slice of the held token (registered)
//   out_last              final beat of a token (registered)
module pe_conv_split #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 16,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Reject parameter sets that cannot be split into whole beats.
  if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_param_check
    $fatal(1, "pe_conv_split: IN_W must be a multiple of OUT_W with ratio >= 2");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IN_W-1:0]    hold_q, hold_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic               in_xfer_c;
  logic               out_xfer_c;

  // Select beat idx of a token, honouring the emission order.
  function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0]  tok,
                                                input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] sel;
    logic [OUT_W-1:0] res;
    res = '0;
    sel = MSB_FIRST ? (LAST_IDX - idx) : idx;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (sel == IDX_W'(i)) res = tok[i*OUT_W +: OUT_W];
    end
    return res;
  endfunction

  // Ready when empty, or when the last beat leaves this cycle (zero-bubble reload).
  assign out_xfer_c = out_valid_q && out_ready;
  assign in_ready   = (state_q == ST_EMPTY) || (out_xfer_c && out_last_q);
  assign in_xfer_c  = in_valid && in_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_last_d  = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (in_xfer_c) begin
          hold_d  = in_data;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (out_xfer_c) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_xfer_c) begin
              hold_d  = in_data;
              state_d = ST_BUSY;
            end else begin
              state_d = ST_EMPTY;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end
    endcase

    // Outputs are computed from the next state so they leave straight from flops.
    if (state_d == ST_BUSY) begin
      out_valid_d = 1'b1;
      out_data_d  = slice_of(hold_d, idx_d);
      out_last_d  = (idx_d == LAST_IDX);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      idx_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pe_conv_split.sv
// Testbench for pe_conv_split: table-driven vectors on an LSB-first instance,
// plus a hand-written sequence on an MSB-first instance.
module tb_pe_conv_split;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] in_data;
  logic [15:0] out_data;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_last;
  logic [31:0] m_in_data;
  logic [15:0] m_out_data;

  always #5 clk = ~clk;

  pe_conv_split #(.IN_W(32), .OUT_W(16), .MSB_FIRST(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  pe_conv_split #(.IN_W(32), .OUT_W(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_data(m_out_data), .out_last(m_out_last)
  );

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_last;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic ev, input logic [15:0] ed,
                              input logic el, input logic er);
    vec_t v;
    v.rst_n = r; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_ready = er;
    vecs.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_in_valid = 1'b0; m_in_data = '0; m_out_ready = 1'b1;

    // Each row: inputs driven this cycle, outputs expected before the next edge.
    //   rst iv  in_data        ordy ev  exp_data  el  er
    add(0, 0, 32'h0000_0000, 0, 0, 16'h0000, 0, 1);  // in reset
    add(1, 0, 32'h0000_0000, 1, 0, 16'h0000, 0, 1);  // idle after release
    // single token, LSB first
    add(1, 1, 32'h1234_ABCD, 1, 0, 16'h0000, 0, 1);
    add(1, 0, 32'h0000_0000, 1, 1, 16'hABCD, 0, 0);
    add(1, 0, 32'h0000_0000, 1, 1, 16'h1234, 1, 1);
    add(1, 0, 32'h0000_0000, 1, 0, 16'h0000, 0, 1);
    // back-to-back tokens, second held valid until taken on the last beat
    add(1, 1, 32'h0000_0001, 1, 0, 16'h0000, 0, 1);
    add(1, 1, 32'hFFFF_8000, 1, 1, 16'h0001, 0, 0);
    add(1, 1, 32'hFFFF_8000, 1, 1, 16'h0000, 1, 1);
    add(1, 0, 32'h0000_0000, 1, 1, 16'h8000, 0, 0);
    add(1, 0, 32'h0000_0000, 1, 1, 16'hFFFF, 1, 1);
    add(1, 0, 32'h0000_0000, 1, 0, 16'h0000, 0, 1);
    // backpressure on beat 0 and on the last beat; junk input must be ignored
    add(1, 1, 32'hDEAD_BEEF, 1, 0, 16'h0000, 0, 1);
    add(1, 0, 32'h5555_5555, 0, 1, 16'hBEEF, 0, 0);
    add(1, 1, 32'h1111_1111, 0, 1, 16'hBEEF, 0, 0);
    add(1, 1, 32'h2222_2222, 0, 1, 16'hBEEF, 0, 0);
    add(1, 0, 32'h0000_0000, 1, 1, 16'hBEEF, 0, 0);
    add(1, 1, 32'h3333_3333, 0, 1, 16'hDEAD, 1, 0);
    add(1, 0, 32'h0000_0000, 1, 1, 16'hDEAD, 1, 1);
    add(1, 0, 32'h0000_0000, 1, 0, 16'h0000, 0, 1);
    // reset mid-token, then a fresh token
    add(1, 1, 32'hCAFE_F00D, 1, 0, 16'h0000, 0, 1);
    add(1, 0, 32'h0000_0000, 1, 1, 16'hF00D, 0, 0);
    add(0, 1, 32'hCAFE_F00D, 1, 0, 16'h0000, 0, 1);
    add(1, 1, 32'h0002_0003, 1, 0, 16'h0000, 0, 1);
    add(1, 0, 32'h0000_0000, 1, 1, 16'h0003, 0, 0);
    add(1, 0, 32'h0000_0000, 1, 1, 16'h0002, 1, 1);
    add(1, 0, 32'h0000_0000, 1, 0, 16'h0000, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n     = vecs[i].rst_n;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("row%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
      check($sformatf("row%0d out_last", i),  32'(out_last),  32'(vecs[i].exp_last));
      check($sformatf("row%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_ready));
    end
    in_valid = 1'b0;

    // MSB-first instance: most-significant slice first, with a stall on beat 0
    @(negedge clk);
    m_in_valid = 1'b1; m_in_data = 32'h7FFF_0001; m_out_ready = 1'b1;
    #1;
    check("msb idle out_valid", 32'(m_out_valid), 32'd0);
    check("msb idle in_ready",  32'(m_in_ready),  32'd1);
    @(negedge clk);
    m_in_valid = 1'b0; m_in_data = 32'hAAAA_AAAA; m_out_ready = 1'b0;
    #1;
    check("msb stall out_data", 32'(m_out_data),  32'h7FFF);
    check("msb stall in_ready", 32'(m_in_ready),  32'd0);
    @(negedge clk);
    m_out_ready = 1'b1;
    #1;
    check("msb beat0 out_data", 32'(m_out_data),  32'h7FFF);
    check("msb beat0 out_last", 32'(m_out_last),  32'd0);
    @(negedge clk);
    #1;
    check("msb beat1 out_data", 32'(m_out_data),  32'h0001);
    check("msb beat1 out_last", 32'(m_out_last),  32'd1);
    check("msb beat1 in_ready", 32'(m_in_ready),  32'd1);
    @(negedge clk);
    #1;
    check("msb done out_valid", 32'(m_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
